fetch_prefetch: RTL

Instruction-fetch front end for the 5-stage MIPS32 pipeline. It sits directly upstream of the IF/ID pipeline register and replaces the free-running PC. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory. Returned instructions are buffered in a small prefetch FIFO and handed to decode under a valid/ready handshake; a branch/jump redirect flushes the FIFO and discards any in-flight responses.

---
 rtl/fetch_prefetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory and buffers returned words in a small FIFO.
module fetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pcplus4,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          pop;
  logic [31:0]   redirect_base;

  // Slots already promised: buffered words plus responses that will be kept.
  assign occupancy     = {1'b0, count_reg} + {1'b0, outstanding_reg} - {1'b0, drop_cnt_reg};
  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = reset && !redirect && (occupancy < DEPTH_W);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live = imem_rsp_valid && (outstanding_reg != '0);
  assign rsp_drop = rsp_live && (drop_cnt_reg != '0);
  assign rsp_keep = rsp_live && (drop_cnt_reg == '0) && !redirect;

  assign out_valid   = (count_reg != '0) && !redirect;
  assign pop         = out_valid && out_ready;
  assign out_instr   = instr_mem[rd_ptr_reg];
  assign out_pcplus4 = pc4_mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the old path, including any
      // response arriving in this very cycle.
      fetch_pc_reg    <= redirect_base;
      rsp_pc_reg      <= redirect_base;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= outstanding_reg - CW'(rsp_live);
      drop_cnt_reg    <= outstanding_reg - CW'(rsp_live);
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_live);
      if (rsp_drop) begin
        drop_cnt_reg <= drop_cnt_reg - CW'(1);
      end
      if (rsp_keep) begin
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(rsp_keep) - CW'(pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          instr_mem[gi] <= '0;
          pc4_mem[gi]   <= '0;
        end else if (rsp_keep && (wr_ptr_reg == AW'(gi))) begin
          instr_mem[gi] <= imem_rsp_data;
          pc4_mem[gi]   <= rsp_pc_reg + 32'd4;
        end
      end
    end
  endgenerate

endmodule
